seven_display_ctrl: RTL and testbench
=====================================

Name: seven_display_ctrl

Overview:
- Parametrised N-digit seven-segment display controller. Successor to the fixed two-digit combinational decoder used for the time-left readout.
- Adds:
  - a registered shadow latch loaded by strobe;
  - per-digit decimal-point control;
  - leading-zero blanking;
  - per-digit blinking from an internal divider;
  - lamp test.
- Sits between the game/timer logic and the board HEX outputs. Each digit's output uses the existing active-low {dp_n, gfedcba} HEX format.

Parameters:
- DIGITS, 4: number of digits, legal range 1..8. Digit 0 is least significant.
- BLINK_DIV, 25000000: clock cycles per blink half-period, legal range >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  when high, captures digits_in, dp_in and blank_lz into the shadow registers at the clock edge.
- digits_in  input  4*DIGITS  BCD digits packed; digit i occupies bits [4i+3:4i].
- dp_in  input  DIGITS  decimal-point enable per digit; 1 = dp lit.
- blank_lz  input  1  leading-zero blanking enable; latched on load.
- blink_en  input  1  enables the blink divider.
- blink_mask  input  DIGITS  digits that blink while blink_en=1; used live, not latched.
- lamp_test  input  1  forces every segment and dp on; used live.
- hex_out  output  8*DIGITS  digit i occupies bits [8i+7:8i] = {dp_n, g, f, e, d, c, b, a}, active-low, registered.
- blink_phase  output  1  current blink phase; 1 = visible half.

Behaviour:
- Reset (rst_n=0, immediate, asynchronous):
  - shadow digits = 4'hF;
  - shadow dp = 0;
  - shadow blank_lz = 0;
  - blink counter = 0;
  - blink_phase = 1;
  - hex_out = all ones (every digit dark).
- Reset asserted mid-blink or mid-load discards all state. After release the outputs stay dark until the first load.
- Decode, per nibble, active-low gfedcba:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10..15 = 1111111 (dark). The dp bit is still driven by the shadow dp.
- dp_n = ~dp for every digit that is not blanked and not in the blink-off state.
- Leading-zero blanking (shadow blank_lz=1):
  - Scan from digit DIGITS-1 downward.
  - A digit is blanked (8'hFF) while its value is 0 and its shadow dp=0.
  - Blanking stops at the first nonzero digit or the first digit with dp set.
  - Digit 0 is never blanked.
- Blink divider (blink_en=1):
  - Counter runs 0..BLINK_DIV-1.
  - On the wrap, blink_phase toggles and the counter returns to 0.
  - When blink_en=0: counter is held at 0 and blink_phase is forced to 1 on the next edge.
  - When blink_en rises: the first toggle occurs BLINK_DIV cycles later.
- Blink-off state: while blink_phase=0, digits with blink_mask[i]=1 output 8'hFF.
- Output priority per digit, evaluated each cycle, highest first:
  1. lamp_test gives 8'h00.
  2. Blink-off gives 8'hFF.
  3. Leading-zero blanking gives 8'hFF.
  4. Otherwise the decoded value with dp.
- Latency:
  - load sampled at edge k updates the shadow at edge k. The new value appears on hex_out after edge k+1, i.e. 2 cycles from strobe to pins.
  - lamp_test, blink_mask and blink_phase changes appear on hex_out after the next edge (1 cycle).
- Simultaneous events:
  - load together with lamp_test: the shadow is still updated. Output shows 8'h00 until lamp_test drops, then the new value.
  - load during blink: the divider is unaffected; there is no phase restart.
- Back-to-back loads on consecutive cycles: each is captured; the last one wins.

Test Plan (DIGITS=4, BLINK_DIV=4):
- Reset release, no load -> hex_out = 32'hFFFFFFFF, blink_phase = 1.
- load digits_in = 16'h1234, dp_in = 4'b0001, blank_lz = 0 -> 2 cycles later hex_out = {8'hF9, 8'hA4, 8'hB0, 8'h19}. Digit 0 = 0x19 because its dp is lit.
- load 16'h0050, dp_in = 0, blank_lz = 1 -> hex_out = {8'hFF, 8'hFF, 8'h92, 8'hC0}. Then load 16'h0005, dp_in = 4'b0010 -> {8'hFF, 8'hFF, 8'h40, 8'h92}, showing "0.5".
- Value 16'h00A7, blank_lz = 0 -> digit 1 = 8'hFF, digit 0 = 8'hF8.
- Display 1234, blink_en = 1, blink_mask = 4'b0011 -> blink_phase toggles every 4 cycles. Digits 0 and 1 read 8'hFF during phase 0; digits 2 and 3 stay unchanged. Dropping blink_en restores the full display 1 cycle after blink_phase returns to 1.
- lamp_test = 1 during blink phase 0 -> all digits 8'h00 next cycle. Assert rst_n = 0 mid-test -> hex_out = all ones immediately, with no clock required.

Source files
------------

// File: rtl/seven_display_ctrl_if.sv
// rtl/seven_display_ctrl_if.sv - display controller signal bundle
interface seven_display_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic                  blink_en;
  logic [DIGITS-1:0]     blink_mask;
  logic                  lamp_test;
  logic [8*DIGITS-1:0]   hex_out;
  logic                  blink_phase;

  modport master (
    output load, digits_in, dp_in, blank_lz, blink_en, blink_mask, lamp_test,
    input  hex_out, blink_phase
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz, blink_en, blink_mask, lamp_test,
    output hex_out, blink_phase
  );
endinterface

// File: rtl/seven_display_ctrl.sv
// rtl/seven_display_ctrl.sv - N-digit seven-segment controller with blanking, blink and lamp test
module seven_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input logic                 clk,
  input logic                 rst_n,
  seven_display_ctrl_if.slave bus
);
  localparam int CW = $clog2(BLINK_DIV);

  logic [4*DIGITS-1:0] sh_digits;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;
  logic [CW-1:0]       blink_cnt;
  logic                phase;
  logic [8*DIGITS-1:0] hex_q;
  logic [8*DIGITS-1:0] hex_next;
  logic [DIGITS-1:0]   lz_blank;
  logic                scanning;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '1;
      sh_dp     <= '0;
      sh_blz    <= 1'b0;
    end else if (bus.load) begin
      sh_digits <= bus.digits_in;
      sh_dp     <= bus.dp_in;
      sh_blz    <= bus.blank_lz;
    end
  end

  // Phase is held visible while disabled so a re-enable always starts on the lit half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!bus.blink_en) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk down from the most significant digit; a zero with its dp set ends the run.
  always_comb begin
    lz_blank = '0;
    scanning = sh_blz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scanning && (sh_digits[4*i +: 4] == 4'd0) && !sh_dp[i])
        lz_blank[i] = 1'b1;
      else
        scanning = 1'b0;
    end
  end

  always_comb begin
    hex_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.lamp_test)
        hex_next[8*i +: 8] = 8'h00;
      else if (!phase && bus.blink_mask[i])
        hex_next[8*i +: 8] = 8'hFF;
      else if (lz_blank[i])
        hex_next[8*i +: 8] = 8'hFF;
      else
        hex_next[8*i +: 8] = {~sh_dp[i], seg_decode(sh_digits[4*i +: 4])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hex_q <= '1;
    else
      hex_q <= hex_next;
  end

  assign bus.hex_out     = hex_q;
  assign bus.blink_phase = phase;
endmodule

// File: tb/tb_seven_display_ctrl.sv
// tb/tb_seven_display_ctrl.sv - scoreboard bench for seven_display_ctrl
module tb_seven_display_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   c;

  int          q_due[$];
  logic [31:0] q_hex[$];
  logic        q_ph[$];
  string       q_name[$];

  seven_display_ctrl_if #(.DIGITS(4)) bus ();

  seven_display_ctrl #(.DIGITS(4), .BLINK_DIV(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act_h, input logic [31:0] exp_h,
                       input logic act_p, input logic exp_p);
    vectors++;
    if (act_h !== exp_h || act_p !== exp_p) begin
      miscompares++;
      $display("FAIL %s: hex_out=%h blink_phase=%b, expected hex_out=%h blink_phase=%b",
               nm, act_h, act_p, exp_h, exp_p);
    end
  endtask

  task automatic expect_at(input string nm, input logic [31:0] h, input logic p, input int due);
    q_name.push_back(nm);
    q_hex.push_back(h);
    q_ph.push_back(p);
    q_due.push_back(due);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic blz);
    bus.load      = 1'b1;
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.blank_lz  = blz;
    step(1);
    bus.load      = 1'b0;
  endtask

  // Monitor: compare each scheduled expectation at the falling edge of its due cycle.
  always @(negedge clk) begin
    while (q_due.size() > 0 && q_due[0] <= cyc) begin
      if (q_due[0] < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: checked late at cycle %0d, required cycle %0d", q_name[0], cyc, q_due[0]);
      end else begin
        check(q_name[0], bus.hex_out, q_hex[0], bus.blink_phase, q_ph[0]);
      end
      void'(q_due.pop_front());
      void'(q_hex.pop_front());
      void'(q_ph.pop_front());
      void'(q_name.pop_front());
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blank_lz   = 1'b0;
    bus.blink_en   = 1'b0;
    bus.blink_mask = '0;
    bus.lamp_test  = 1'b0;
    step(3);
    check("reset_hold", bus.hex_out, 32'hFFFFFFFF, bus.blink_phase, 1'b1);
    rst_n = 1'b1;
    c = cyc;
    expect_at("reset_release", 32'hFFFFFFFF, 1'b1, c + 2);
    step(3);

    c = cyc;
    expect_at("load_1234_dp0", 32'hF9A4B019, 1'b1, c + 2);
    do_load(16'h1234, 4'b0001, 1'b0);
    step(2);

    c = cyc;
    expect_at("lz_0050", 32'hFFFF92C0, 1'b1, c + 2);
    do_load(16'h0050, 4'b0000, 1'b1);
    step(2);

    c = cyc;
    expect_at("lz_0p5", 32'hFFFF4092, 1'b1, c + 2);
    do_load(16'h0005, 4'b0010, 1'b1);
    step(2);

    c = cyc;
    expect_at("invalid_00a7", 32'hC0C0FFF8, 1'b1, c + 2);
    do_load(16'h00A7, 4'b0000, 1'b0);
    step(2);

    c = cyc;
    expect_at("load_1234", 32'hF9A4B099, 1'b1, c + 2);
    do_load(16'h1234, 4'b0000, 1'b0);
    step(2);

    c = cyc;
    bus.blink_mask = 4'b0011;
    bus.blink_en   = 1'b1;
    expect_at("blink_first_toggle", 32'hF9A4B099, 1'b0, c + 4);
    expect_at("blink_off",          32'hF9A4FFFF, 1'b0, c + 5);
    expect_at("blink_back_on",      32'hF9A4FFFF, 1'b1, c + 8);
    expect_at("blink_visible",      32'hF9A4B099, 1'b1, c + 9);
    expect_at("blink_second_off",   32'hF9A4B099, 1'b0, c + 12);
    expect_at("blink_drop_phase",   32'hF9A4FFFF, 1'b1, c + 13);
    expect_at("blink_drop_restore", 32'hF9A4B099, 1'b1, c + 14);
    step(12);
    bus.blink_en = 1'b0;
    step(3);

    c = cyc;
    bus.blink_en = 1'b1;
    step(4);
    bus.lamp_test = 1'b1;
    expect_at("lamp_in_phase0", 32'h00000000, 1'b0, c + 5);
    step(1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.hex_out, 32'hFFFFFFFF, bus.blink_phase, 1'b1);
    bus.lamp_test  = 1'b0;
    bus.blink_en   = 1'b0;
    bus.blink_mask = 4'b0000;
    step(2);
    rst_n = 1'b1;
    c = cyc;
    expect_at("dark_after_reset_a", 32'hFFFFFFFF, 1'b1, c + 1);
    expect_at("dark_after_reset_b", 32'hFFFFFFFF, 1'b1, c + 3);
    step(4);

    c = cyc;
    bus.lamp_test = 1'b1;
    expect_at("lamp_with_load_a", 32'h00000000, 1'b1, c + 1);
    expect_at("lamp_with_load_b", 32'h00000000, 1'b1, c + 2);
    expect_at("lamp_release",     32'h9080F882, 1'b1, c + 3);
    do_load(16'h9876, 4'b0000, 1'b0);
    step(1);
    bus.lamp_test = 1'b0;
    step(3);

    c = cyc;
    expect_at("b2b_first",  32'hF9F9F9F9, 1'b1, c + 2);
    expect_at("b2b_last",   32'hFFFF99A4, 1'b1, c + 3);
    bus.load      = 1'b1;
    bus.digits_in = 16'h1111;
    bus.dp_in     = 4'b0000;
    bus.blank_lz  = 1'b0;
    step(1);
    bus.digits_in = 16'h0042;
    bus.blank_lz  = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(3);

    for (int i = 0; i < 20 && q_due.size() > 0; i++) step(1);
    if (q_due.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", q_due.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
